// File: rtl/ps2_rx_framer_if.sv
// PS/2 receive framer signal bundle: raw pin levels and the receive enable go
// into the framer, and the byte strobe and status come back out. The framer
// itself uses the slave view. The line driver or scancode controller uses the
// master view.
interface ps2_rx_framer_if;
  logic       ps2_clk_in;
  logic       ps2_dat_in;
  logic       rx_enable;
  logic [7:0] rx;
  logic       rx_valid;
  logic       error;
  logic       rx_busy;

  modport master (
    output ps2_clk_in,
    output ps2_dat_in,
    output rx_enable,
    input  rx,
    input  rx_valid,
    input  error,
    input  rx_busy
  );

  modport slave (
    input  ps2_clk_in,
    input  ps2_dat_in,
    input  rx_enable,
    output rx,
    output rx_valid,
    output error,
    output rx_busy
  );
endinterface

// File: rtl/ps2_rx_framer.sv
// PS/2 device-to-host deframer. Each raw line passes through a 2-flop
// synchroniser and a run-length glitch filter. The 11-bit frame (start bit,
// 8 data bits LSB first, odd parity, stop bit) is assembled on falling edges
// of the filtered clock. Every finished, failed or timed-out frame produces a
// one-cycle strobe.
module ps2_rx_framer #(
  parameter int clkf       = 50000000,
  parameter int filter_len = 8,
  parameter int timeout_us = 2000
) (
  input  logic           clk,
  input  logic           reset,
  ps2_rx_framer_if.slave bus
);

  localparam int TIMEOUT_CYCLES = (clkf / 1000000) * timeout_us;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW = $clog2(filter_len + 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] FILT_LAST = CW'(filter_len - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // Bit 0 carries the clock line and bit 1 the data line. Both lines use the
  // same filter so that their relative timing is preserved.
  logic [1:0] raw_lines;
  logic [1:0] filt_lines;

  assign raw_lines = {bus.ps2_dat_in, bus.ps2_clk_in};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_line
      logic          sync1_reg;
      logic          sync2_reg;
      logic          filt_reg;
      logic [CW-1:0] cnt_reg;

      // Synchronise the raw pin, then flip the filtered level only after
      // filter_len consecutive disagreeing samples.
      always_ff @(posedge clk) begin
        if (reset) begin
          sync1_reg <= 1'b1;
          sync2_reg <= 1'b1;
          filt_reg  <= 1'b1;
          cnt_reg   <= '0;
        end else begin
          sync1_reg <= raw_lines[gi];
          sync2_reg <= sync1_reg;
          if (sync2_reg == filt_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == FILT_LAST) begin
            filt_reg <= ~filt_reg;
            cnt_reg  <= '0;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
      end

      assign filt_lines[gi] = filt_reg;
    end
  endgenerate

  logic f_clk;
  logic f_dat;
  logic fall;

  assign f_clk = filt_lines[0];
  assign f_dat = filt_lines[1];

  state_t        state_reg, state_next;
  logic [2:0]    idx_reg, idx_next;
  logic [7:0]    shift_reg, shift_next;
  logic          par_reg, par_next;
  logic [TW-1:0] to_cnt_reg, to_cnt_next;
  logic [7:0]    rx_reg, rx_next;
  logic          rx_valid_reg, rx_valid_next;
  logic          error_reg, error_next;
  logic          prev_clk_reg;
  logic          busy_reg;

  assign fall = prev_clk_reg & ~f_clk;

  // Frame sequencing and timeout supervision. An inhibited receive overrides
  // everything else. A falling edge takes precedence over an expiring timeout.
  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    shift_next    = shift_reg;
    par_next      = par_reg;
    to_cnt_next   = to_cnt_reg;
    rx_next       = 8'h00;
    rx_valid_next = 1'b0;
    error_next    = 1'b0;

    if (!bus.rx_enable) begin
      state_next  = IDLE;
      to_cnt_next = '0;
    end else if (fall) begin
      to_cnt_next = '0;
      case (state_reg)
        IDLE: begin
          if (!f_dat) begin
            state_next = DATA;
            idx_next   = 3'd0;
            shift_next = 8'h00;
          end
        end
        DATA: begin
          shift_next[idx_reg] = f_dat;
          idx_next            = idx_reg + 3'd1;
          if (idx_reg == 3'd7) begin
            state_next = PARITY;
          end
        end
        PARITY: begin
          par_next   = f_dat;
          state_next = STOP;
        end
        STOP: begin
          rx_valid_next = 1'b1;
          rx_next       = shift_reg;
          error_next    = ((^{shift_reg, par_reg}) != 1'b1) | ~f_dat;
          state_next    = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end else if (state_reg == IDLE) begin
      to_cnt_next = '0;
    end else if (to_cnt_reg == TO_LAST) begin
      rx_valid_next = 1'b1;
      error_next    = 1'b1;
      state_next    = IDLE;
      to_cnt_next   = '0;
    end else begin
      to_cnt_next = to_cnt_reg + TW'(1);
    end
  end

  // State, datapath and output registers. Busy is decoded from the previous
  // state, so it stays high through the end-of-frame strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      idx_reg      <= 3'd0;
      shift_reg    <= 8'h00;
      par_reg      <= 1'b0;
      to_cnt_reg   <= '0;
      rx_reg       <= 8'h00;
      rx_valid_reg <= 1'b0;
      error_reg    <= 1'b0;
      prev_clk_reg <= 1'b1;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      shift_reg    <= shift_next;
      par_reg      <= par_next;
      to_cnt_reg   <= to_cnt_next;
      rx_reg       <= rx_next;
      rx_valid_reg <= rx_valid_next;
      error_reg    <= error_next;
      prev_clk_reg <= f_clk;
      busy_reg     <= (state_reg != IDLE);
    end
  end

  assign bus.rx       = rx_reg;
  assign bus.rx_valid = rx_valid_reg;
  assign bus.error    = error_reg;
  assign bus.rx_busy  = busy_reg;

endmodule

// File: tb/tb_ps2_rx_framer.sv
// Testbench for ps2_rx_framer. A 12.5 kHz PS/2 clock runs against a 1 MHz
// system clock. Expected strobes are queued as frames are driven and are
// compared when the strobe appears, including its latency after the last raw
// falling edge.
module tb_ps2_rx_framer;

  localparam int CLKF   = 1000000;
  localparam int FL     = 8;
  localparam int TO_US  = 200;
  localparam int TO_CYC = (CLKF / 1000000) * TO_US;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  ps2_rx_framer_if bus();

  ps2_rx_framer #(
    .clkf      (CLKF),
    .filter_len(FL),
    .timeout_us(TO_US)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [7:0] rx;
    logic       err;
    bit         to;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   last_fall_e0 = 0;
  bit   mon_on = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: pop and compare on every rx_valid, and require quiet
  // outputs on every other cycle.
  always @(negedge clk) begin : mon
    exp_t e;
    if (mon_on) begin
      if (bus.rx_valid) begin
        check_val("strobe_expected", 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check_val("rx_byte", 32'(bus.rx), 32'(e.rx));
          check_val("rx_error", 32'(bus.error), 32'(e.err));
          check_val("busy_at_strobe", 32'(bus.rx_busy), 32'd1);
          check_val("strobe_latency", 32'(cyc - last_fall_e0),
                    32'(FL + 2 + (e.to ? TO_CYC : 0)));
          $display("txn: cycle=%0d rx=%02h error=%0d timeout_frame=%0d", cyc, bus.rx, bus.error, e.to);
        end
      end else begin
        check_val("idle_rx", 32'(bus.rx), 32'd0);
        check_val("idle_error", 32'(bus.error), 32'd0);
      end
    end
  end

  // One PS/2 bit cell: data is set while the clock is high, then the clock
  // falls, and an optional short low glitch is inserted before the real edge.
  task automatic ps2_bit(input logic v, input bit glitch);
    bus.ps2_dat_in = v;
    if (glitch) begin
      repeat (10) @(negedge clk);
      bus.ps2_clk_in = 1'b0;
      repeat (3) @(negedge clk);
      bus.ps2_clk_in = 1'b1;
      repeat (7) @(negedge clk);
    end else begin
      repeat (20) @(negedge clk);
    end
    bus.ps2_clk_in = 1'b0;
    last_fall_e0 = cyc + 1;
    repeat (40) @(negedge clk);
    bus.ps2_clk_in = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] b, input logic par, input logic stop,
                           input int nbits, input int glitch_bit);
    logic [10:0] fr;
    fr = {stop, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(fr[i], i == glitch_bit);
    bus.ps2_dat_in = 1'b1;
  endtask

  task automatic full_frame(input logic [7:0] b, input logic par_flip, input logic stop,
                            input int glitch_bit);
    exp_t e;
    logic par;
    par = (~^b) ^ par_flip;
    e.rx  = b;
    e.err = ((^b ^ par) != 1'b1) || (stop == 1'b0);
    e.to  = 1'b0;
    sb_q.push_back(e);
    send_bits(b, par, stop, 11, glitch_bit);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : stim
    exp_t e;
    bus.ps2_clk_in = 1'b1;
    bus.ps2_dat_in = 1'b1;
    bus.rx_enable  = 1'b1;
    repeat (3) @(negedge clk);
    check_val("reset_rx_valid", 32'(bus.rx_valid), 32'd0);
    check_val("reset_rx", 32'(bus.rx), 32'd0);
    check_val("reset_error", 32'(bus.error), 32'd0);
    check_val("reset_busy", 32'(bus.rx_busy), 32'd0);
    reset = 1'b0;
    mon_on = 1'b1;
    repeat (20) @(negedge clk);

    // Good frames, a parity error, and a stop-bit error.
    full_frame(8'h1C, 1'b0, 1'b1, -1);
    full_frame(8'h1C, 1'b1, 1'b1, -1);
    full_frame(8'hF0, 1'b0, 1'b1, -1);
    full_frame(8'h5A, 1'b0, 1'b0, -1);
    check_val("busy_after_stop_err", 32'(bus.rx_busy), 32'd0);

    // A short clock glitch while idle, then another inside a frame.
    repeat (10) @(negedge clk);
    bus.ps2_clk_in = 1'b0;
    repeat (3) @(negedge clk);
    bus.ps2_clk_in = 1'b1;
    repeat (30) @(negedge clk);
    check_val("busy_after_idle_glitch", 32'(bus.rx_busy), 32'd0);
    full_frame(8'h3B, 1'b0, 1'b1, 4);

    // Timeout after the start bit and 4 data bits.
    e.rx = 8'h00; e.err = 1'b1; e.to = 1'b1;
    sb_q.push_back(e);
    send_bits(8'h33, ~^8'h33, 1'b1, 5, -1);
    repeat (TO_CYC + 50) @(negedge clk);

    // Inhibit mid-frame: the partial frame is dropped silently.
    send_bits(8'hA5, ~^8'hA5, 1'b1, 6, -1);
    bus.rx_enable = 1'b0;
    repeat (30) @(negedge clk);
    check_val("busy_inhibited", 32'(bus.rx_busy), 32'd0);
    bus.rx_enable = 1'b1;
    repeat (20) @(negedge clk);
    full_frame(8'h7E, 1'b0, 1'b1, -1);

    // One-cycle reset mid-frame, then a clean frame.
    send_bits(8'h44, ~^8'h44, 1'b1, 7, -1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_val("midreset_rx_valid", 32'(bus.rx_valid), 32'd0);
    check_val("midreset_rx", 32'(bus.rx), 32'd0);
    check_val("midreset_error", 32'(bus.error), 32'd0);
    check_val("midreset_busy", 32'(bus.rx_busy), 32'd0);
    repeat (TO_CYC + 50) @(negedge clk);
    full_frame(8'h29, 1'b0, 1'b1, -1);

    repeat (50) @(negedge clk);
    check_val("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
